// File: rtl/contador_paquetes.sv
// contador_paquetes
//   Packet counter and query responder for the output side of the 4-in/4-out FIFO switch.
//   Counts successful pops on output FIFOs 4..7, answers a registered req/idx count query,
//   and keeps sticky flags for pops attempted while a FIFO is empty.
//
// Parameters
//   CNT_W      width of each per-FIFO counter; counters saturate at 2**CNT_W-1
//   NUM_F      number of output FIFOs counted (fixed at 4; idx is 2 bits)
//
// Ports
//   clk        single clock, everything on posedge
//   reset      synchronous active-high reset, overrides every other input
//   init       level; while high, counters and pop_err are held cleared
//   pop4..7    pop strobes seen by output FIFOs 4..7
//   empty4..7  empty flags of output FIFOs 4..7
//   req        level-sensitive query request
//   idx        counter select, 0 -> FIFO4 .. 3 -> FIFO7
//   cnt_data   selected count, registered, holds its value when req is low
//   cnt_valid  cnt_data carries the answer to the previous cycle's req
//   pop_err    sticky pop-on-empty flags, bit i belongs to FIFO 4+i
//   idle       registered; high when the next state is COUNT and req is low

module contador_paquetes #(
  parameter int unsigned CNT_W = 5,
  parameter int unsigned NUM_F = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             pop4,
  input  logic             pop5,
  input  logic             pop6,
  input  logic             pop7,
  input  logic             empty4,
  input  logic             empty5,
  input  logic             empty6,
  input  logic             empty7,
  input  logic             req,
  input  logic [1:0]       idx,
  output logic [CNT_W-1:0] cnt_data,
  output logic             cnt_valid,
  output logic [3:0]       pop_err,
  output logic             idle
);

  typedef enum logic [1:0] {
    StReset = 2'd0,
    StInit  = 2'd1,
    StCount = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;

  // Gather the per-FIFO strobes into vectors so the counting logic can be looped.
  logic [NUM_F-1:0] pop_vec;
  logic [NUM_F-1:0] empty_vec;

  assign pop_vec   = {pop7, pop6, pop5, pop4};
  assign empty_vec = {empty7, empty6, empty5, empty4};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [NUM_F];
  logic [CNT_W-1:0] cnt_d [NUM_F];
  logic [NUM_F-1:0] err_q, err_d;
  logic [CNT_W-1:0] cnt_data_q, cnt_data_d;
  logic             cnt_valid_q, cnt_valid_d;
  logic             idle_q, idle_d;

  // Counting is only live in COUNT with init low; INIT, or init rising while in COUNT,
  // clears the counters and flags on the same edge.
  logic count_en;
  logic clear_en;

  assign count_en = (state_q == StCount) && !init;
  assign clear_en = (state_q != StReset) && init;

  // Next state: every non-reset state leaves on the init level alone.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReset: state_d = init ? StInit : StCount;
      StInit:  state_d = init ? StInit : StCount;
      StCount: state_d = init ? StInit : StCount;
      default: state_d = StReset;
    endcase
  end

  // Per-FIFO counters and sticky pop-on-empty flags.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (clear_en) begin
      for (int unsigned i = 0; i < NUM_F; i++) begin
        cnt_d[i] = '0;
      end
      err_d = '0;
    end else if (count_en) begin
      for (int unsigned i = 0; i < NUM_F; i++) begin
        if (pop_vec[i]) begin
          if (empty_vec[i]) begin
            err_d[i] = 1'b1;
          end else if (cnt_q[i] != CntMax) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
      end
    end
  end

  // Query path reads the pre-edge counter, so a pop on the same edge is not included.
  // No answer is given while still in RESET; cnt_data holds when nothing is answered.
  always_comb begin
    cnt_data_d  = cnt_data_q;
    cnt_valid_d = 1'b0;
    if (req && (state_q != StReset)) begin
      cnt_valid_d = 1'b1;
      cnt_data_d  = (state_q == StInit) ? '0 : cnt_q[idx];
    end
  end

  always_comb begin
    idle_d = (state_d == StCount) && !req;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StReset;
      for (int unsigned i = 0; i < NUM_F; i++) begin
        cnt_q[i] <= '0;
      end
      err_q       <= '0;
      cnt_data_q  <= '0;
      cnt_valid_q <= 1'b0;
      idle_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      for (int unsigned i = 0; i < NUM_F; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      err_q       <= err_d;
      cnt_data_q  <= cnt_data_d;
      cnt_valid_q <= cnt_valid_d;
      idle_q      <= idle_d;
    end
  end

  assign cnt_data  = cnt_data_q;
  assign cnt_valid = cnt_valid_q;
  assign pop_err   = err_q;
  assign idle      = idle_q;

endmodule
